// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - two-requester arbiter for the single ram256x8 MOV/MOC port
module mem_access_arbiter #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_done,
  output logic [31:0] f_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [2:0]  d_ms,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        mov,
  output logic        mem_rw,
  output logic [2:0]  mem_ms,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  input  logic        moc,
  input  logic [31:0] mem_dout,
  output logic        busy,
  output logic        owner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  // Last ACCESS cycle index: the abort fires on the edge ending the TIMEOUT_CYCLES-th cycle.
  localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t     state, state_next;
  logic [7:0] tcnt;
  logic [3:0] starve_cnt;
  logic       grant_any, grant_d, acc_moc, acc_tmo;

  // MOV and BUSY are pure decodes of the state register, so a reset drops them at once.
  assign mov  = (state == S_ACCESS);
  assign busy = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state decode plus the grant and access-end strobes used by the datapath.
  always_comb begin
    state_next = state;
    grant_any  = 1'b0;
    grant_d    = 1'b0;
    acc_moc    = 1'b0;
    acc_tmo    = 1'b0;
    case (state)
      S_IDLE: begin
        grant_any = f_req | d_req;
        grant_d   = d_req & ~(f_req & (starve_cnt == STARVE_MAX));
        if (grant_any) state_next = S_ACCESS;
      end
      S_ACCESS: begin
        acc_moc = moc;
        acc_tmo = ~moc & (tcnt == TCNT_LAST);
        if (acc_moc | acc_tmo) state_next = S_RECOVER;
      end
      S_RECOVER: begin
        if (!moc) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Grant latching, timeout/starve counting, completion pulses and read-data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner      <= 1'b0;
      mem_rw     <= 1'b0;
      mem_ms     <= 3'b000;
      mem_addr   <= 32'h0;
      mem_din    <= 32'h0;
      f_done     <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      f_rdata    <= 32'h0;
      d_rdata    <= 32'h0;
      tcnt       <= 8'h0;
      starve_cnt <= 4'h0;
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
      err    <= 1'b0;
      if (grant_any) begin
        tcnt <= 8'h0;
        if (grant_d) begin
          owner      <= 1'b1;
          mem_rw     <= d_rw;
          mem_ms     <= d_ms;
          mem_addr   <= d_addr;
          mem_din    <= d_wdata;
          starve_cnt <= f_req ? starve_cnt + 4'd1 : 4'h0;
        end else begin
          owner      <= 1'b0;
          mem_rw     <= 1'b1;
          mem_ms     <= 3'b010;
          mem_addr   <= f_addr;
          mem_din    <= 32'h0;
          starve_cnt <= 4'h0;
        end
      end
      if (acc_moc | acc_tmo) begin
        f_done <= ~owner;
        d_done <= owner;
        err    <= acc_tmo;
        if (mem_rw) begin
          if (owner) d_rdata <= acc_moc ? mem_dout : 32'h0;
          else       f_rdata <= acc_moc ? mem_dout : 32'h0;
        end
      end else if (state == S_ACCESS) begin
        tcnt <= tcnt + 8'd1;
      end
      if (state == S_RECOVER && !moc) tcnt <= 8'h0;
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb/tb_mem_access_arbiter.sv - scoreboard bench for mem_access_arbiter
module tb_mem_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, d_req, d_rw, moc;
  logic [31:0] f_addr, d_addr, d_wdata, mem_dout;
  logic [2:0]  d_ms;
  logic        f_done, d_done, err, mov, mem_rw, busy, owner;
  logic [31:0] f_rdata, d_rdata, mem_addr, mem_din;
  logic [2:0]  mem_ms;

  mem_access_arbiter #(.TIMEOUT_CYCLES(15), .STARVE_LIMIT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_ms(d_ms), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .err(err),
    .mov(mov), .mem_rw(mem_rw), .mem_ms(mem_ms), .mem_addr(mem_addr), .mem_din(mem_din),
    .moc(moc), .mem_dout(mem_dout), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        owner;
    logic        err;
    logic [31:0] rdata;
    logic        rw;
    logic [2:0]  ms;
    logic [31:0] addr;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;

  logic [31:0] ram [256];
  bit          ram_en = 1'b1;
  int          ram_lat = 2;
  int          ram_hold = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic void expect_done(input logic o, input logic e, input logic [31:0] rd,
                                      input logic rw, input logic [2:0] ms, input logic [31:0] a);
    sb_entry_t x;
    x.owner = o; x.err = e; x.rdata = rd; x.rw = rw; x.ms = ms; x.addr = a;
    sb.push_back(x);
  endfunction

  // RAM model: MOC after ram_lat cycles of MOV, held ram_hold extra cycles.
  initial begin
    moc = 1'b0;
    mem_dout = 32'h0;
    forever begin
      @(negedge clk);
      if (mov && ram_en) begin
        for (int k = 1; k < ram_lat; k++) @(negedge clk);
        if (mem_rw) mem_dout = ram[mem_addr[7:0]];
        else        ram[mem_addr[7:0]] = mem_din;
        moc = 1'b1;
        for (int k = 0; k <= ram_hold; k++) @(negedge clk);
        moc = 1'b0;
      end
    end
  end

  // Monitor: every DONE pops one expected completion.
  initial begin
    sb_entry_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (f_done || d_done)) begin
        done_cnt++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got f_done=%0b d_done=%0b expected none", f_done, d_done);
        end else begin
          e = sb.pop_front();
          check("done_is_d", {31'h0, d_done}, {31'h0, e.owner});
          check("done_is_f", {31'h0, f_done}, {31'h0, ~e.owner});
          check("owner_out", {31'h0, owner}, {31'h0, e.owner});
          check("err", {31'h0, err}, {31'h0, e.err});
          check("rdata", e.owner ? d_rdata : f_rdata, e.rdata);
          check("mem_rw", {31'h0, mem_rw}, {31'h0, e.rw});
          check("mem_ms", {29'h0, mem_ms}, {29'h0, e.ms});
          check("mem_addr", mem_addr, e.addr);
        end
      end
    end
  end

  task automatic drive(input bit is_d, input bit rw, input logic [2:0] ms,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (is_d) begin
      d_req = 1'b1; d_rw = rw; d_ms = ms; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
  endtask

  task automatic run_req(input bit is_d, input bit rw, input logic [2:0] ms,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit exp_err, input logic [31:0] exp_rdata,
                         output int mov_cycles, output int first_mov);
    bit got = 1'b0;
    expect_done(is_d, exp_err, exp_rdata, is_d ? rw : 1'b1, is_d ? ms : 3'b010, addr);
    @(posedge clk); #1;
    drive(is_d, rw, ms, addr, wdata);
    mov_cycles = 0;
    first_mov  = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (mov) begin
        mov_cycles++;
        if (first_mov == 0) first_mov = i;
      end
      if (is_d ? d_done : f_done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("done_wait_expired", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (is_d) d_req = 1'b0;
    else      f_req = 1'b0;
  endtask

  initial begin
    int mc, fm, rec, target;
    bit seen;
    for (int i = 0; i < 256; i++) ram[i] = 32'h0;
    ram[8'h10] = 32'h12345678;
    rst_n = 1'b0;
    f_req = 1'b0; f_addr = 32'h0;
    d_req = 1'b0; d_rw = 1'b0; d_ms = 3'b000; d_addr = 32'h0; d_wdata = 32'h0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_mov", {31'h0, mov}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_owner", {31'h0, owner}, 32'd0);
    check("rst_dones", {30'h0, f_done, d_done}, 32'd0);
    check("rst_err", {31'h0, err}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_ctl", {28'h0, mem_rw, mem_ms}, 32'h0);
    check("rst_f_rdata", f_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    rst_n = 1'b1;

    // Fetch read, MOC two cycles after MOV.
    ram_lat = 2;
    run_req(1'b0, 1'b1, 3'b010, 32'h10, 32'h0, 1'b0, 32'h12345678, mc, fm);
    check("f_mov_latency", fm, 2);
    check("f_mov_cycles", mc, 2);
    @(negedge clk);
    check("f_busy_after", {31'h0, busy}, 32'd0);

    // Store then load through D; a later store leaves D_RDATA alone.
    run_req(1'b1, 1'b0, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0, 32'h0, mc, fm);
    run_req(1'b1, 1'b1, 3'b010, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, mc, fm);
    run_req(1'b1, 1'b0, 3'b001, 32'h24, 32'h11112222, 1'b0, 32'hCAFEF00D, mc, fm);
    check("ram_store", ram[8'h24], 32'h11112222);

    // Both held: starvation guard yields D,D,D,F,D,D,D,F.
    ram_lat = 1;
    for (int g = 0; g < 8; g++) begin
      if (g == 3 || g == 7) expect_done(1'b0, 1'b0, 32'h12345678, 1'b1, 3'b010, 32'h10);
      else                  expect_done(1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 3'b010, 32'h30);
    end
    target = done_cnt + 8;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'b010, 32'h30, 32'hA5A5A5A5);
    drive(1'b0, 1'b1, 3'b010, 32'h10, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (done_cnt >= target) begin
        seen = 1'b1;
        break;
      end
    end
    #1;
    f_req = 1'b0;
    d_req = 1'b0;
    if (!seen) check("starve_wait_expired", 32'd0, 32'd1);
    check("ram_starve_store", ram[8'h30], 32'hA5A5A5A5);

    // MOC never arrives: abort after 15 ACCESS cycles with ERR.
    ram_en = 1'b0;
    run_req(1'b1, 1'b1, 3'b010, 32'h40, 32'h0, 1'b1, 32'h0, mc, fm);
    check("tmo_mov_cycles", mc, 15);
    @(negedge clk);
    check("tmo_busy_after", {31'h0, busy}, 32'd0);

    // MOC held 3 extra cycles: F waits in RECOVER until MOC clears.
    ram_en = 1'b1;
    ram_lat = 1;
    ram_hold = 3;
    expect_done(1'b1, 1'b0, 32'h0, 1'b0, 3'b010, 32'h50);
    expect_done(1'b0, 1'b0, 32'h11112222, 1'b1, 3'b010, 32'h24);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 3'b010, 32'h50, 32'h0BADBEEF);
    drive(1'b0, 1'b1, 3'b010, 32'h24, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (d_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("hold_d_wait_expired", 32'd0, 32'd1);
    rec = 1;
    @(posedge clk); #1;
    d_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mov) begin
        seen = 1'b1;
        break;
      end
      if (busy) rec++;
    end
    if (!seen) check("hold_f_grant_expired", 32'd0, 32'd1);
    check("hold_recover_cycles", rec, 4);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (f_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("hold_f_wait_expired", 32'd0, 32'd1);
    @(posedge clk); #1;
    f_req = 1'b0;
    for (int i = 0; i < 50 && busy; i++) @(negedge clk);
    ram_hold = 0;

    // Reset mid-ACCESS abandons the access; the next request runs normally.
    ram_en = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 3'b010, 32'h20, 32'h0);
    for (int i = 0; i < 20 && !mov; i++) @(negedge clk);
    @(negedge clk);
    check("pre_rst_mov", {31'h0, mov}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_mov", {31'h0, mov}, 32'd0);
    check("async_rst_busy", {31'h0, busy}, 32'd0);
    check("async_rst_d_rdata", d_rdata, 32'h0);
    d_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ram_en = 1'b1;
    ram_lat = 2;
    run_req(1'b1, 1'b1, 3'b010, 32'h20, 32'h0, 1'b0, 32'hCAFEF00D, mc, fm);
    check("post_rst_mov_cycles", mc, 2);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
